mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-access memory controller; define MEM_ARB_RR_EN for round-robin ties, else port 0 wins.
// Latency: gnt at T, mem_addr/mem_we at T+1, done with rdata at T+3, next grant no earlier than T+4.
// Backpressure: req is held until gnt; one transaction in flight; a memory fault parks the arbiter in ERR until rst.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_done,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_error,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4,
        ERR   = 3'd5
    } state_t;

    typedef struct packed {
        logic                  port;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } txn_t;

    state_t                state_q;
    state_t                state_d;
    txn_t                  txn_q;
    txn_t                  txn_sel;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  grant;
    logic                  winner;
    logic                  resp_ok;

`ifdef MEM_ARB_RR_EN
    // Port granted most recently; reset to 1 so port 0 takes the first tie.
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= winner;
        end
    end

    always_comb begin
        if (req0 && req1) begin
            winner = ~last_q;
        end else begin
            winner = ~req0;
        end
    end
`else
    always_comb begin
        winner = ~req0;
    end
`endif

    always_comb begin
        txn_sel.port  = winner;
        txn_sel.we    = winner ? we1 : we0;
        txn_sel.addr  = winner ? addr1 : addr0;
        txn_sel.wdata = winner ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            BOOT: begin
                if (boot_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (boot_done && (req0 || req1)) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = mem_error ? ERR : WAIT;
            WAIT:  state_d = mem_error ? ERR : RESP;
            RESP:  state_d = mem_error ? ERR : IDLE;
            ERR:   state_d = ERR;
            default: state_d = BOOT;
        endcase
    end

    // A fault seen in RESP kills the completion, so done and the rdata update both depend on it.
    assign resp_ok = (state_q == RESP) && !mem_error && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_q   <= '0;
            mem_we  <= 1'b0;
            rdata_q <= '0;
        end else begin
            mem_we <= 1'b0;
            if (grant && !rst) begin
                txn_q  <= txn_sel;
                mem_we <= txn_sel.we;
            end
            if (resp_ok && !txn_q.we) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign gnt0      = grant && !winner && !rst;
    assign gnt1      = grant && winner && !rst;
    assign done0     = resp_ok && !txn_q.port;
    assign done1     = resp_ok && txn_q.port;
    // Read data is forwarded during RESP so it is valid in the done cycle, then held.
    assign rdata     = (resp_ok && !txn_q.we) ? mem_rdata : rdata_q;
    assign mem_addr  = txn_q.addr;
    assign mem_wdata = txn_q.wdata;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == RESP);
    assign err       = (state_q == ERR);

    assert property (@(posedge clk) !(gnt0 && gnt1));
    assert property (@(posedge clk) !(done0 && done1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed boot/read/write/tie/reset/fault steps, then random two-port traffic
// checked against a transaction-level model of grant order, completion timing and memory contents.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, boot_done, req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_error;
    logic          busy, err;

    // Memory controller stand-in: combinational read of the registered address, write on mem_we.
    logic [DW-1:0] tb_mem [16] = '{default: '0};
    logic          rd_force_en;
    logic [DW-1:0] rd_force;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [16];
    logic          pend [2];
    logic          granted [2];
    logic          op_we [2];
    logic [AW-1:0] op_addr [2];
    logic [DW-1:0] op_wdata [2];
    logic          last_w, w, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata, last_rdata;
    logic [1:0]    exp_g, exp_d;
    int            free_cyc, d_cyc, d_port;
    int            gcyc[$];
    int            gport[$];

    always #5 clk = ~clk;

    assign mem_rdata = rd_force_en ? rd_force : tb_mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[3:0]] <= mem_wdata;
    end

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .boot_done(boot_done),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_error(mem_error), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_next;
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; boot_done = 1'b0; mem_error = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rd_force_en = 1'b0; rd_force = '0;

        // Reset values
        to_next; to_next;
        to_sample;
        chk("reset_ctrl", 32'({gnt0, gnt1, done0, done1, mem_we, busy, err}), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);

        // Requests are ignored until boot_done
        to_next;
        rst = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            to_sample;
            chk("boot_no_gnt", 32'({gnt0, gnt1}), 32'd0);
            to_next;
        end
        boot_done = 1'b1;
        to_sample;
        chk("boot_edge_no_gnt", 32'({gnt0, gnt1}), 32'd0);
        to_next;
        to_sample;
        chk("read_gnt0", 32'({gnt0, gnt1}), 32'b10);
        rd_force_en = 1'b1; rd_force = 16'h0001;
        to_next;
        req0 = 1'b0;    // dropped mid-transaction; must still complete
        to_sample;
        chk("read_mem_addr", 32'(mem_addr), 32'h0004);
        chk("read_mem_we", 32'(mem_we), 32'd0);
        chk("read_busy", 32'(busy), 32'd1);
        to_next;
        to_sample;
        chk("read_no_early_done", 32'({done0, done1}), 32'd0);
        to_next;
        to_sample;
        chk("read_done0", 32'({done0, done1}), 32'b10);
        chk("read_rdata", 32'(rdata), 32'h0001);

        // Write from port 1
        to_next;
        rd_force_en = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0010; wdata1 = 16'hBEEF;
        to_sample;
        chk("write_gnt1", 32'({gnt0, gnt1}), 32'b01);
        chk("read_rdata_held", 32'(rdata), 32'h0001);
        chk("idle_busy", 32'(busy), 32'd0);
        to_next;
        to_sample;
        chk("write_mem_we", 32'(mem_we), 32'd1);
        chk("write_mem_addr", 32'(mem_addr), 32'h0010);
        chk("write_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        to_next;
        req1 = 1'b0;
        to_sample;
        chk("write_mem_we_one_cycle", 32'(mem_we), 32'd0);
        to_next;
        to_sample;
        chk("write_done1", 32'({done0, done1}), 32'b01);
        chk("write_rdata_unchanged", 32'(rdata), 32'h0001);

        // Both ports held high for four transactions
        to_next;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        for (int i = 0; i < 16; i++) begin
            to_sample;
            if (gnt0 || gnt1) begin
                gcyc.push_back(i);
                gport.push_back(gnt1 ? 1 : 0);
            end
            to_next;
        end
        chk("tie_grant_count", 32'(gcyc.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gcyc.size()) begin
                chk("tie_grant_cycle", 32'(gcyc[k]), 32'(4 * k));
                chk("tie_grant_port", 32'(gport[k]), RR ? 32'(k % 2) : 32'd0);
            end
        end

        // Reset during WAIT abandons the transaction
        req1 = 1'b0; addr0 = 16'h0008;
        to_sample;
        chk("rstwait_gnt0", 32'({gnt0, gnt1}), 32'b10);
        to_next;
        to_next;
        rst = 1'b1;
        to_next;
        rst = 1'b0; req1 = 1'b1; addr1 = 16'h0003;
        to_sample;
        chk("rstwait_ctrl_zero", 32'({gnt0, gnt1, done0, done1, mem_we, busy, err}), 32'd0);
        chk("rstwait_rdata_zero", 32'(rdata), 32'd0);
        chk("rstwait_mem_addr_zero", 32'(mem_addr), 32'd0);
        chk("rstwait_mem_wdata_zero", 32'(mem_wdata), 32'd0);
        to_next;
        to_sample;
        chk("first_tie_after_rst", 32'({gnt0, gnt1}), 32'b10);
        to_next;
        req0 = 1'b0; req1 = 1'b0;
        to_next;
        to_next;
        to_sample;
        chk("rstwait_rereq_done0", 32'({done0, done1}), 32'b10);

        // Random traffic against the transaction-level model
        to_next;
        rst = 1'b1;
        to_next;
        rst = 1'b0; boot_done = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_mem[0] = 16'hBEEF;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; granted[p] = 1'b0;
            op_we[p] = 1'b0; op_addr[p] = '0; op_wdata[p] = '0;
        end
        last_w = 1'b1; free_cyc = 1; d_cyc = -10; d_port = 0;
        t_we = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0; last_rdata = '0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]     = 1'b1;
                    granted[p]  = 1'b0;
                    op_we[p]    = 1'($urandom_range(0, 1));
                    op_addr[p]  = 16'($urandom);
                    op_wdata[p] = 16'($urandom);
                end
            end
            req0 = pend[0] && (!granted[0] || ($urandom_range(0, 1) == 1));
            req1 = pend[1] && (!granted[1] || ($urandom_range(0, 1) == 1));
            we0 = op_we[0]; addr0 = op_addr[0]; wdata0 = op_wdata[0];
            we1 = op_we[1]; addr1 = op_addr[1]; wdata1 = op_wdata[1];
            to_sample;

            exp_g = 2'b00;
            if (c >= free_cyc && (req0 || req1)) begin
                if (req0 && req1) w = RR ? !last_w : 1'b0;
                else              w = !req0;
                exp_g   = w ? 2'b10 : 2'b01;
                last_w  = w;
                free_cyc = c + 4;
                d_cyc   = c + 3;
                d_port  = w ? 1 : 0;
                t_we    = op_we[d_port];
                t_addr  = op_addr[d_port];
                t_wdata = op_wdata[d_port];
                if (t_we) ref_mem[t_addr[3:0]] = t_wdata;
                else      t_rdata = ref_mem[t_addr[3:0]];
                granted[d_port] = 1'b1;
            end
            chk("rnd_gnt", 32'({gnt1, gnt0}), 32'(exp_g));

            exp_d = 2'b00;
            if (c == d_cyc) begin
                exp_d = (d_port == 1) ? 2'b10 : 2'b01;
                if (!t_we) last_rdata = t_rdata;
            end
            chk("rnd_done", 32'({done1, done0}), 32'(exp_d));
            chk("rnd_rdata", 32'(rdata), 32'(last_rdata));
            chk("rnd_mem_we", 32'(mem_we), 32'((c == d_cyc - 2) && t_we));
            chk("rnd_busy", 32'(busy), 32'((c >= d_cyc - 2) && (c <= d_cyc)));
            if (c == d_cyc - 2) begin
                chk("rnd_mem_addr", 32'(mem_addr), 32'(t_addr));
                if (t_we) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(t_wdata));
            end
            if (c == d_cyc) begin
                pend[d_port]    = 1'b0;
                granted[d_port] = 1'b0;
            end
            to_next;
        end

        // Memory fault in WAIT locks the arbiter until reset
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) to_next;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
        to_sample;
        chk("fault_gnt0", 32'({gnt0, gnt1}), 32'b10);
        to_next;
        req0 = 1'b0;
        to_next;
        mem_error = 1'b1;
        to_next;
        mem_error = 1'b0;
        to_sample;
        chk("fault_err", 32'(err), 32'd1);
        chk("fault_no_done", 32'({done0, done1, busy}), 32'd0);
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            to_next;
            to_sample;
            chk("fault_locked", 32'({gnt0, gnt1, done0, done1, mem_we}), 32'd0);
            chk("fault_err_sticky", 32'(err), 32'd1);
        end
        to_next;
        rst = 1'b1;
        to_next;
        rst = 1'b0;
        to_sample;
        chk("fault_cleared_by_rst", 32'({err, busy, gnt0, gnt1}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
